// File: rtl/hier_pipe_chain.sv
// Elastic valid/ready pipeline of DEPTH register stages (u_stg[0] is the input end).
// Define HIER_PIPE_REVERSE_EN to bit-reverse out_data; stage contents are never reversed.

module hier_pipe_stage #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             v;
  logic [WIDTH-1:0] d;
  logic             ready;

  assign ready = !v || down_ready;
  assign valid = v;
  assign data  = d;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v <= 1'b0;
    end else if (ready) begin
      v <= up_valid;
    end
  end

  // Payload carries no reset; it is only meaningful while v is set.
  always_ff @(posedge clk) begin
    if (ready) begin
      d <= up_data;
    end
  end

endmodule

module hier_pipe_chain #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned DW = DEPTH * WIDTH;

  logic [DEPTH-1:0] stg_up_valid;
  logic [DEPTH-1:0] stg_down_ready;
  logic [DEPTH-1:0] stg_valid;
  logic [DW-1:0]    stg_up_data;
  logic [DW-1:0]    stg_data;
  logic             head_ready;
  logic [WIDTH-1:0] tail_d;
  logic             accept;
  logic             emit;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Stage k is fed by stage k-1; stage 0 is fed by the input port.
  assign stg_up_valid = (stg_valid << 1) | DEPTH'(in_valid);
  assign stg_up_data  = (stg_data << WIDTH) | DW'(in_data);

  // Ready seen by stage k: out_ready, or any empty stage further down the chain.
  // Computed from the v registers directly so no combinational loop through the stages.
  always_comb begin
    logic r;
    stg_down_ready = '0;
    r = out_ready;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      stg_down_ready[k] = r;
      r = r || !stg_valid[k];
    end
    head_ready = r;
  end

  hier_pipe_stage #(
    .WIDTH(WIDTH)
  ) u_stg [DEPTH-1:0] (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .up_valid  (stg_up_valid),
    .up_data   (stg_up_data),
    .down_ready(stg_down_ready),
    .valid     (stg_valid),
    .data      (stg_data)
  );

  assign tail_d    = stg_data[(DEPTH-1)*WIDTH +: WIDTH];
  assign in_ready  = head_ready && !flush;
  assign out_valid = stg_valid[DEPTH-1];

`ifdef HIER_PIPE_REVERSE_EN
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_rev
    assign out_data[i] = tail_d[WIDTH-1-i];
  end
`else
  assign out_data = tail_d;
`endif

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  // Occupancy tracks the v bits edge for edge.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(accept) - CNT_W'(emit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_hier_pipe_chain.sv
// Scoreboard bench for hier_pipe_chain (WIDTH=4, DEPTH=3); honours HIER_PIPE_REVERSE_EN.

module tb_hier_pipe_chain;

  localparam int W  = 4;
  localparam int D  = 3;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [CW-1:0] count;

  int            n_checks = 0;
  int            n_pass   = 0;
  int            emit_cnt = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  got_q[$];
  logic [W-1:0]  stream_exp[3];
  logic [W-1:0]  bp_words[4];

  hier_pipe_chain #(
    .WIDTH(W),
    .DEPTH(D),
    .CNT_W(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] xform(input logic [W-1:0] x);
    logic [W-1:0] r;
`ifdef HIER_PIPE_REVERSE_EN
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
`else
    r = x;
`endif
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue side: a word accepted at the coming edge gets its expected output queued.
  always @(negedge clk) begin
    if (!rst && !flush && in_valid && in_ready) exp_q.push_back(xform(in_data));
  end

  // Monitor: a word leaving at the coming edge is compared against the queue head.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      emit_cnt++;
      got_q.push_back(out_data);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL out_unexpected: got %0d, want no word", out_data);
      end else begin
        check("out_data", int'(out_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int acc;
`ifdef HIER_PIPE_REVERSE_EN
    stream_exp = '{4'd9, 4'd10, 4'd3};
`else
    stream_exp = '{4'd9, 4'd5, 4'd12};
`endif
    bp_words = '{4'd3, 4'd6, 4'd11, 4'd14};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);

    // Stream 9, 5, 12 with the tail always ready.
    got_q.delete();
    in_valid = 1'b1; in_data = 4'd9;
    step(); check("lat_edge0", out_valid, 0);
    in_data = 4'd5;
    step(); check("lat_edge1", out_valid, 0);
    in_data = 4'd12;
    step(); check("lat_edge2", out_valid, 1);
    in_valid = 1'b0;
    step(); check("b2b_edge3", out_valid, 1);
    step(); check("b2b_edge4", out_valid, 1);
    step(); check("drained_edge5", out_valid, 0);
    check("stream_n", got_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (got_q.size() > i) check("stream_word", int'(got_q[i]), int'(stream_exp[i]));
    end

    // Hierarchical probe of the stage registers.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'd9;
    step();
    in_valid = 1'b0;
    step();
    check("probe_s0_v", dut.u_stg[0].v, 0);
    check("probe_s1_v", dut.u_stg[1].v, 1);
    check("probe_s1_d", dut.u_stg[1].d, 9);
    step();
    check("probe_s2_v", dut.u_stg[2].v, 1);
    check("probe_s2_d", dut.u_stg[2].d, 9);
    out_ready = 1'b1;
    repeat (2) step();
    check("probe_drain_count", count, 0);

    // Backpressure: four offers into a stalled chain.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data = bp_words[acc];
      #1;
      if (in_ready) acc++;
      step();
    end
    #1;
    check("bp_accepted", acc, 3);
    check("bp_in_ready", in_ready, 0);
    check("bp_count", count, 3);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("bp_drain_count", count, 0);
    check("bp_drain_queue", exp_q.size(), 0);

    // Full chain flowing one word per cycle.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 4'(i + 1);
      step();
    end
    check("flow_full", count, 3);
    emit_cnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 4'(i + 4);
      step();
      check("flow_count", count, 3);
    end
    in_valid = 1'b0;
    check("flow_emitted", emit_cnt, 8);
    repeat (4) step();
    check("flow_drain_queue", exp_q.size(), 0);

    // Flush with two words inside and a word on offer.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 4'd1; step();
    in_data = 4'd2; step();
    check("flush_pre_count", count, 2);
    flush = 1'b1;
    in_data = 4'd15;
    exp_q.delete();
    #1;
    check("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_count", count, 0);
    check("flush_out_valid", out_valid, 0);
    got_q.delete();
    in_valid = 1'b1; in_data = 4'd6; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check("flush_after_n", got_q.size(), 1);
    if (got_q.size() > 0) check("flush_after_word", int'(got_q[0]), 6);

    // Reset in the middle of a stream.
    in_valid = 1'b1; in_data = 4'd10;
    step();
    in_data = 4'd13;
    step();
    rst = 1'b1;
    exp_q.delete();
    step();
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_count", count, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_mid_in_ready", in_ready, 1);
    repeat (3) step();
    check("rst_mid_queue", exp_q.size(), 0);
    check("rst_mid_out_valid_late", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hier_pipe_chain.md
# hier_pipe_chain

Parametrised elastic pipeline of DEPTH register stages carrying a WIDTH-bit word with valid/ready flow control. It succeeds the fixed 4-bit nested pass-through hierarchy: the combinational wiring is replaced by a registered, back-pressurable chain. Each stage is a named sub-instance whose state is readable by hierarchical reference from the bench. An optional output bit-order reversal reproduces the [MSB:0] to [0:MSB] port remap in hardware.

## Interface
- WIDTH, 4: payload width in bits, 1 or more.
- DEPTH, 3: number of register stages, 1 or more.
- CNT_W, 3: width of the occupancy count; 2**CNT_W must exceed DEPTH.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all stage contents.
- in_valid  in  1  upstream word present.
- in_data  in  WIDTH  upstream word, bit [WIDTH-1] is the MSB.
- in_ready  out  1  chain accepts in_data this cycle.
- out_valid  out  1  word present at the chain tail.
- out_data  out  WIDTH  tail word.
- out_ready  in  1  downstream consumes the tail word.
- count  out  CNT_W  number of occupied stages.

## Operation
- Stages are instances u_stg[0] to u_stg[DEPTH-1] of sub-module hier_pipe_stage. Each holds registers v (valid) and d (WIDTH data). u_stg[0] is the input end.
- Stage k advances when its downstream side takes its word. For the tail this is out_ready. For other stages it is the ready of stage k+1.
- Stage k ready = !v or (advancing). Ready propagates combinationally tail to head, so a full, flowing chain sustains 1 word per cycle.
- On an update, stage k loads v and d from stage k-1 (from in_valid/in_data for k=0). It keeps its value when not ready.
- A word is never dropped or duplicated except by flush or rst.
- in_ready = ready of u_stg[0] and !flush.
- out_valid = u_stg[DEPTH-1].v.
- out_data = u_stg[DEPTH-1].d, transformed per Configuration.
- count = sum of all v bits, registered consistently with v (no lag).
- Handshake rules: in_data is accepted on the cycle when in_valid and in_ready are both high. A tail word leaves on the cycle when out_valid and out_ready are both high. in_valid may be asserted without waiting for in_ready.
- Data registers d are not reset. Only v is cleared, and d is don't-care while v=0.

## Timing
- Reset: rst high at a rising edge forces all v=0 on that edge. rst overrides flush and traffic.
- Output values after reset: out_valid=0, count=0, in_ready=1 (when flush=0). out_data is undefined until the first word arrives.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N+DEPTH-1. This holds when the chain is unstalled (DEPTH register hops including the capture edge).
- Full chain, out_ready=0: in_ready=0 and count=DEPTH, holding indefinitely.
- Full chain, out_ready=1: accept and emit occur on the same edge and count stays DEPTH.
- Flush: all v=0 on that edge and the input word is dropped (in_ready forced 0). The tail word is not considered consumed even if out_ready=1.
- rst or flush mid-transfer: in-flight words are discarded with no partial output.
- Bubbles: an empty stage always accepts, and bubbles collapse when the tail stalls.

## Configuration
- HIER_PIPE_REVERSE_EN defined: out_data[i] = u_stg[DEPTH-1].d[WIDTH-1-i]. This gives bit-order reversal at the output only; stage contents are unreversed.
- HIER_PIPE_REVERSE_EN undefined: out_data = u_stg[DEPTH-1].d unchanged.
- Handshake, latency and count are identical in both builds.

## Test plan
- Reset then stream, WIDTH=4, DEPTH=3, out_ready=1:
  - Stimulus: send 9, 5, 12 on consecutive cycles.
  - Required: out_valid rises 2 edges after first accept, and out_data gives 9, 5, 12 back-to-back.
  - With HIER_PIPE_REVERSE_EN: out_data gives 9, 10, 3.
- Hierarchical probe:
  - Stimulus: accept 9 with out_ready=0, then wait one edge.
  - Required: u_stg[0].v=0 and u_stg[1].d=9 with u_stg[1].v=1 (via hierarchical reference). After the next edge u_stg[2].d=9.
- Backpressure:
  - Stimulus: hold out_ready=0 and offer 4 words.
  - Required: 3 accepted, in_ready=0, count=3. Raising out_ready drains them in order with no loss.
- Full flow-through:
  - Stimulus: full chain, out_ready=1 and in_valid=1 for 8 cycles.
  - Required: count stays 3 and exactly 8 words emerge in order.
- Flush and reset:
  - Stimulus: flush with count=2 while in_valid=1.
  - Required: count=0 next cycle and the offered word is absent from the output.
  - Stimulus: assert rst mid-stream.
  - Required: out_valid=0 and count=0 after that edge.
